// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: per-line scan of the sprite attribute table.
// Walks the first N_ENTRIES entries, finds sprites that cover LINE_Y,
// and queues hit records in a 4-deep FWFT FIFO for the pixel fetcher.
//
// Optional build macro: SPRITE_SCAN_FLIPY_EN
//   defined   -> entry bit [3] is a vertical-flip flag, colour is 3 bits
//   undefined -> entry bits [3:0] are the colour, row is never mirrored
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   LINE_START, LINE_Y  start-of-scan pulse and scanline to evaluate
//   TBL_RD_ADDR/DATA    sprite table read port (1-cycle read latency)
//   HIT_VALID/READY     valid/ready handshake for the FIFO head
//   HIT_X/TILE/ROW/COLOR  fields of the FIFO head record
//   SCAN_BUSY           high while a scan is in progress
//   SCAN_DONE           one-cycle pulse once the last entry is evaluated
//   OVERFLOW            a hit was dropped on this line (MAX_HITS reached)

module sprite_line_scanner #(
  parameter int unsigned N_ENTRIES = 64,
  parameter int unsigned SPRITE_H  = 16,
  parameter int unsigned MAX_HITS  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LINE_START,
  input  logic [8:0]  LINE_Y,
  output logic [8:0]  TBL_RD_ADDR,
  input  logic [31:0] TBL_RD_DATA,
  output logic        HIT_VALID,
  input  logic        HIT_READY,
  output logic [9:0]  HIT_X,
  output logic [7:0]  HIT_TILE,
  output logic [3:0]  HIT_ROW,
  output logic [3:0]  HIT_COLOR,
  output logic        SCAN_BUSY,
  output logic        SCAN_DONE,
  output logic        OVERFLOW
);

  localparam int unsigned IDX_W = 10;
  localparam int unsigned CNT_W = $clog2(MAX_HITS + 1);
  localparam int unsigned REC_W = 26;
  localparam int unsigned DEPTH = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t             state;
  logic [8:0]         line_y_q;
  logic [IDX_W-1:0]   rd_idx;
  logic [CNT_W-1:0]   hit_cnt;
  logic               rd_pend;
  logic [REC_W-1:0]   fifo_mem [DEPTH];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [2:0]         fifo_count;

  logic [8:0]         diff;
  logic               hit;
  logic               hit_full;
  logic [3:0]         row;
  logic [3:0]         color;
  logic               push;
  logic               pop;
  logic               issue;
  logic [REC_W-1:0]   rec;

  // Evaluate the returning entry and decide issue/push/pop for this cycle
  always_comb begin
    diff     = line_y_q - TBL_RD_DATA[20:12];
    hit      = TBL_RD_DATA[31] && (diff < 9'(SPRITE_H));
    row      = diff[3:0];
    color    = TBL_RD_DATA[3:0];
`ifdef SPRITE_SCAN_FLIPY_EN
    color    = {1'b0, TBL_RD_DATA[2:0]};
    if (TBL_RD_DATA[3]) begin
      row = 4'(SPRITE_H - 1) - diff[3:0];
    end
`endif
    hit_full = (hit_cnt == CNT_W'(MAX_HITS));
    push     = rd_pend && hit && !hit_full;
    pop      = HIT_VALID && HIT_READY;
    // count <= 2 leaves room for the one read in flight plus this cycle's push
    issue    = (state == SCAN) && (fifo_count <= 3'd2) &&
               (rd_idx < IDX_W'(N_ENTRIES));
    rec      = {TBL_RD_DATA[30:21], TBL_RD_DATA[11:4], row, color};
  end

  assign HIT_VALID = (fifo_count != 3'd0);
  assign {HIT_X, HIT_TILE, HIT_ROW, HIT_COLOR} = fifo_mem[rd_ptr];

  // FIFO storage; stale writes during a flush are harmless since pointers reset
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= rec;
    end
  end

  // Scan FSM, read pipeline, hit counting and FIFO pointers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      line_y_q    <= '0;
      rd_idx      <= '0;
      TBL_RD_ADDR <= '0;
      hit_cnt     <= '0;
      rd_pend     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      SCAN_BUSY   <= 1'b0;
      SCAN_DONE   <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      SCAN_DONE <= 1'b0;
      if (LINE_START) begin
        // New line (also aborts a running scan): drop in-flight data, flush
        state       <= SCAN;
        SCAN_BUSY   <= 1'b1;
        line_y_q    <= LINE_Y;
        rd_idx      <= '0;
        TBL_RD_ADDR <= '0;
        hit_cnt     <= '0;
        OVERFLOW    <= 1'b0;
        rd_pend     <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fifo_count  <= '0;
      end else begin
        rd_pend <= issue;

        if (push) begin
          wr_ptr  <= wr_ptr + 2'd1;
          hit_cnt <= hit_cnt + CNT_W'(1);
        end
        if (rd_pend && hit && hit_full) begin
          OVERFLOW <= 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 2'd1;
        end
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 3'd1;
          2'b01:   fifo_count <= fifo_count - 3'd1;
          default: fifo_count <= fifo_count;
        endcase

        case (state)
          SCAN: begin
            if (issue) begin
              rd_idx <= rd_idx + IDX_W'(1);
              // Address holds on the last entry once every read is issued
              if ((rd_idx + IDX_W'(1)) < IDX_W'(N_ENTRIES)) begin
                TBL_RD_ADDR <= 9'(rd_idx + IDX_W'(1));
              end
            end else if (rd_idx == IDX_W'(N_ENTRIES)) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            // Last result has landed in the previous cycle
            state     <= IDLE;
            SCAN_BUSY <= 1'b0;
            SCAN_DONE <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Self-checking bench for sprite_line_scanner: directed cases plus
// randomized lines checked against a per-line reference model.
module tb_sprite_line_scanner;

  localparam int N    = 64;
  localparam int SH   = 16;
  localparam int MAXH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [8:0]  line_y;
  logic [8:0]  tbl_rd_addr;
  logic [31:0] tbl_rd_data;
  logic        hit_valid;
  logic        hit_ready;
  logic [9:0]  hit_x;
  logic [7:0]  hit_tile;
  logic [3:0]  hit_row;
  logic [3:0]  hit_color;
  logic        scan_busy;
  logic        scan_done;
  logic        overflow;

  logic [31:0] mem [512];
  logic [25:0] got [$];
  int          rec_cyc [$];
  logic [25:0] exp_q [$];
  bit          exp_ovf;

  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int tests = 0;
  int fails = 0;

  sprite_line_scanner dut (
    .CLK        (clk),
    .RESET      (rst),
    .LINE_START (line_start),
    .LINE_Y     (line_y),
    .TBL_RD_ADDR(tbl_rd_addr),
    .TBL_RD_DATA(tbl_rd_data),
    .HIT_VALID  (hit_valid),
    .HIT_READY  (hit_ready),
    .HIT_X      (hit_x),
    .HIT_TILE   (hit_tile),
    .HIT_ROW    (hit_row),
    .HIT_COLOR  (hit_color),
    .SCAN_BUSY  (scan_busy),
    .SCAN_DONE  (scan_done),
    .OVERFLOW   (overflow)
  );

  always #5 clk = ~clk;

  // Sprite table RAM, one-cycle read latency
  always @(posedge clk) tbl_rd_data <= mem[tbl_rd_addr];

  // Edge counter, accepted-record capture and SCAN_DONE pulse counting
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (line_start) start_cyc <= cyc;
      if (hit_valid && hit_ready) begin
        got.push_back({hit_x, hit_tile, hit_row, hit_color});
        rec_cyc.push_back(cyc);
      end
      if (scan_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mk(input logic en, input int x, input int y,
                                     input int tile, input int col);
    return {en, 10'(x), 9'(y), 8'(tile), 4'(col)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = '0;
  endtask

  // Reference: walk entries in order, modular row distance, cap at MAXH
  task automatic build_exp(input logic [8:0] ly);
    logic [31:0] e;
    int d;
    int row;
    logic [3:0] col;
    exp_q.delete();
    exp_ovf = 0;
    for (int i = 0; i < N; i++) begin
      e = mem[i];
      d = (int'(ly) - int'(e[20:12]) + 512) % 512;
      if (e[31] && d < SH) begin
        if (exp_q.size() < MAXH) begin
          row = d;
          col = e[3:0];
`ifdef SPRITE_SCAN_FLIPY_EN
          if (e[3]) row = SH - 1 - d;
          col = {1'b0, e[2:0]};
`endif
          exp_q.push_back({e[30:21], e[11:4], 4'(row), col});
        end else begin
          exp_ovf = 1;
        end
      end
    end
  endtask

  task automatic start_line(input logic [8:0] ly);
    @(negedge clk);
    line_start = 1'b1;
    line_y     = ly;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Wait for SCAN_DONE (bounded), drain the FIFO, compare against the model
  task automatic finish_line(input string tag, input logic [8:0] ly,
                             input int d0, input bit rnd);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (rnd) hit_ready = 1'($urandom_range(0, 1));
      if (done_cnt != d0) ok = 1;
    end
    hit_ready = 1'b1;
    for (int i = 0; i < 20 && hit_valid; i++) @(negedge clk);
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy"}, 32'(scan_busy), 32'd0);
    build_exp(ly);
    chk({tag, "_nrec"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_rec"}, 32'(got[i]), 32'(exp_q[i]));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic run_line(input string tag, input logic [8:0] ly, input bit rnd);
    int d0;
    got.delete();
    rec_cyc.delete();
    d0 = done_cnt;
    start_line(ly);
    finish_line(tag, ly, d0, rnd);
  endtask

  initial begin
    int d0;
    logic [8:0] ly;
    rst = 1'b1;
    line_start = 1'b0;
    line_y = '0;
    hit_ready = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);

    chk("rst_valid", 32'(hit_valid), 32'd0);
    chk("rst_busy",  32'(scan_busy), 32'd0);
    chk("rst_done",  32'(scan_done), 32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    chk("rst_addr",  32'(tbl_rd_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single hit at entry 5
    mem[5] = mk(1, 100, 40, 7, 3);
    run_line("single", 9'd45, 0);
    chk("single_lat", 32'(done_cyc - start_cyc - 1), 32'd66);
    if (got.size() > 0) chk("single_fields", 32'(got[0]), 32'({10'd100, 8'd7, 4'd5, 4'd3}));

    // Boundary rows and vertical wrap
    run_line("row0", 9'd40, 0);
    if (got.size() > 0) chk("row0_row", 32'(got[0][7:4]), 32'd0);
    run_line("row15", 9'd55, 0);
    if (got.size() > 0) chk("row15_row", 32'(got[0][7:4]), 32'd15);
    run_line("below", 9'd56, 0);
    run_line("above", 9'd39, 0);
    chk("above_none", 32'(got.size()), 32'd0);
    mem[5] = mk(1, 100, 510, 7, 3);
    run_line("wrap", 9'd2, 0);
    if (got.size() > 0) chk("wrap_row", 32'(got[0][7:4]), 32'd4);

    // First-record latency with entry 0 hitting
    clear_mem();
    mem[0] = mk(1, 33, 40, 9, 1);
    run_line("lat", 9'd41, 0);
    if (rec_cyc.size() > 0) chk("lat_first", 32'(rec_cyc[0] - start_cyc - 1), 32'd2);

    // Overflow: ten hits, only eight kept
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = mk(1, 10 * i + 1, 0, i + 16, i);
    run_line("ovf", 9'd3, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    got.delete();
    d0 = done_cnt;
    start_line(9'd3);
    chk("ovf_clr", 32'(overflow), 32'd0);
    finish_line("ovf2", 9'd3, d0, 0);

    // Back-pressure: FIFO fills, address freezes, nothing lost
    got.delete();
    d0 = done_cnt;
    hit_ready = 1'b0;
    start_line(9'd3);
    repeat (20) @(negedge clk);
    chk("bp_addr", 32'(tbl_rd_addr), 32'd4);
    chk("bp_valid", 32'(hit_valid), 32'd1);
    chk("bp_busy", 32'(scan_busy), 32'd1);
    chk("bp_none", 32'(got.size()), 32'd0);
    repeat (5) @(negedge clk);
    chk("bp_addr2", 32'(tbl_rd_addr), 32'd4);
    hit_ready = 1'b1;
    finish_line("bp", 9'd3, d0, 0);

    // Abort: second LINE_START ten cycles in
    clear_mem();
    for (int i = 30; i < 34; i++) mem[i] = mk(1, i, 100, i, 5);
    mem[5]  = mk(1, 500, 195, 2, 6);
    mem[40] = mk(1, 600, 200, 4, 7);
    got.delete();
    d0 = done_cnt;
    start_line(9'd100);
    repeat (9) @(negedge clk);
    chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
    start_line(9'd200);
    finish_line("abort", 9'd200, d0, 0);

    // Randomized lines with random consumer stalls
    for (int t = 0; t < 8; t++) begin
      clear_mem();
      ly = 9'($urandom_range(0, 511));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0)
          mem[i] = mk(1'($urandom_range(0, 1)), $urandom_range(0, 1023),
                      $urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 15));
        else
          mem[i] = mk(1'($urandom_range(0, 3) != 0), $urandom_range(0, 1023),
                      (int'(ly) + 512 - $urandom_range(0, 40)) % 512,
                      $urandom_range(0, 255), $urandom_range(0, 15));
      end
      run_line("rand", ly, 1);
    end

    // Reset mid-scan with a non-empty FIFO
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = mk(1, i, 0, i, i);
    got.delete();
    d0 = done_cnt;
    hit_ready = 1'b0;
    start_line(9'd3);
    repeat (8) @(negedge clk);
    chk("mrst_pre", 32'(hit_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", 32'(hit_valid), 32'd0);
    chk("mrst_busy", 32'(scan_busy), 32'd0);
    chk("mrst_addr", 32'(tbl_rd_addr), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    hit_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_quiet", 32'(got.size()), 32'd0);
    chk("mrst_nodone", 32'(done_cnt - d0), 32'd0);

    // Flip flag handling (bit 3 of the entry)
    clear_mem();
    mem[5] = mk(1, 100, 40, 7, 4'b1010);
    run_line("flip", 9'd42, 0);
`ifdef SPRITE_SCAN_FLIPY_EN
    if (got.size() > 0) chk("flip_rec", 32'(got[0]), 32'({10'd100, 8'd7, 4'd13, 4'd2}));
`else
    if (got.size() > 0) chk("flip_rec", 32'(got[0]), 32'({10'd100, 8'd7, 4'd2, 4'd10}));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_line_scanner.md
Name: sprite_line_scanner

Overview:
- Read-side consumer of the sprite attribute table that the CPU write decoder fills: 512 × 32-bit sync RAM, 9-bit address, 1-cycle read latency.
- Once per video line, walks the first N_ENTRIES table entries and finds the sprites that intersect the upcoming scanline.
- Streams one hit record per intersecting sprite over a valid/ready interface to the sprite pixel fetcher.
- Hits buffered in a 4-deep internal FIFO; scan throughput is 1 entry/cycle when not back-pressured.

Parameters:
- N_ENTRIES, 64, number of table entries scanned per line, starting at address 0 (1..512).
- SPRITE_H, 16, sprite height in lines (power of 2, ≤16).
- MAX_HITS, 8, max hit records emitted per line; further hits are dropped.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous reset, active-high.
- LINE_START  in  1  one-cycle pulse; starts a scan for LINE_Y.
- LINE_Y  in  9  scanline to be rendered next; sampled on LINE_START.
- TBL_RD_ADDR  out  9  sprite table read address.
- TBL_RD_DATA  in  32  sprite table read data, valid 1 cycle after address.
- HIT_VALID  out  1  FIFO head valid.
- HIT_READY  in  1  consumer accepts head when HIT_VALID & HIT_READY.
- HIT_X  out  10  sprite X of head record.
- HIT_TILE  out  8  tile index of head record.
- HIT_ROW  out  4  row within sprite, 0..SPRITE_H-1.
- HIT_COLOR  out  4  palette select.
- SCAN_BUSY  out  1  high from LINE_START until scan complete.
- SCAN_DONE  out  1  one-cycle pulse when the last entry has been evaluated.
- OVERFLOW  out  1  set when a hit is dropped; cleared on LINE_START.

Behaviour:
- Entry format: [31] enable, [30:21] X, [20:12] Y, [11:4] tile, [3:0] color.
- Reset values:
  - All outputs 0: TBL_RD_ADDR=0, HIT_VALID=0, SCAN_BUSY=0, SCAN_DONE=0, OVERFLOW=0.
  - FIFO emptied; FSM returns to IDLE.
- FSM states:
  - IDLE → on LINE_START: latch LINE_Y, clear rd_idx, hit_cnt and OVERFLOW; flush FIFO; → SCAN.
  - SCAN: issue read rd_idx (TBL_RD_ADDR=rd_idx) and rd_idx++ in any cycle where fifo_count ≤ 2 and rd_idx < N_ENTRIES. Otherwise hold the address and do not advance.
  - SCAN → DRAIN when rd_idx = N_ENTRIES (last read issued).
  - DRAIN: wait 1 cycle for the last data; pulse SCAN_DONE; → IDLE.
  - SCAN_BUSY = (state ≠ IDLE).
- Evaluation, in the cycle TBL_RD_DATA returns for an issued read:
  - diff = (LINE_Y − Y) mod 512, 9-bit unsigned.
  - hit = enable & (diff < SPRITE_H).
  - On hit with hit_cnt < MAX_HITS: push {X, tile, diff[3:0], color}; hit_cnt++.
  - On hit with hit_cnt = MAX_HITS: do not push; set OVERFLOW.
- Wrap-around: diff is modular, so Y=510, LINE_Y=2 gives diff=4, a hit. Sprites wrap vertically by design.
- FIFO:
  - 4 deep, first-word fall-through; HIT_* are driven from the head entry.
  - Push and pop in the same cycle leave the count unchanged.
  - The issue rule (count ≤ 2) guarantees the FIFO never overflows, with at most 2 reads in flight; no push is ever lost.
  - FIFO contents persist after SCAN_DONE until consumed or the next LINE_START.
- LINE_START while SCAN/DRAIN (mid-scan):
  - Abort the current scan and discard the in-flight read result.
  - Flush the FIFO and restart at entry 0 with the new LINE_Y.
  - No SCAN_DONE pulse for the aborted scan.
- RESET mid-scan: immediate return to IDLE with the reset values above; in-flight data discarded.
- Latency: the first record is visible on HIT_* 2 cycles after LINE_START when entry 0 hits (read issued cycle+1, pushed cycle+2).
- Unstalled scan time: N_ENTRIES+2 cycles from LINE_START to SCAN_DONE.

Optional Feature:
- Macro: SPRITE_SCAN_FLIPY_EN.
- Defined:
  - Entry bit [3] is a vertical-flip flag; HIT_COLOR = {1'b0, entry[2:0]}.
  - HIT_ROW = SPRITE_H−1−diff when flip=1, else diff.
- Undefined: bit [3] is part of the 4-bit color; HIT_ROW = diff.

Test Plan:
- Single hit: entry 5 = {en=1, X=100, Y=40, tile=7, color=3}, all others disabled; LINE_START with LINE_Y=45, HIT_READY=1 → exactly one record X=100, TILE=7, ROW=5, COLOR=3; SCAN_DONE pulses 66 cycles after LINE_START.
- Boundary rows: entry Y=40; LINE_Y=40 → ROW=0; LINE_Y=55 → ROW=15; LINE_Y=56 and LINE_Y=39 → no hit. Wrap case Y=510, LINE_Y=2 → ROW=4.
- Overflow: 10 enabled entries all at Y=0, LINE_Y=3 → 8 records, in entries 0–7 order; OVERFLOW=1 after scan; next LINE_START clears it.
- Back-pressure: same 10 entries at MAX_HITS=8 with HIT_READY held low for 20 cycles → FIFO holds 4 entries, TBL_RD_ADDR frozen, no record lost or duplicated after HIT_READY rises.
- Abort: LINE_START at cycle 0, second LINE_START at cycle 10 with a different LINE_Y → no SCAN_DONE for the first scan; only records matching the second LINE_Y are emitted.
- Reset: RESET asserted mid-scan with a non-empty FIFO → next cycle HIT_VALID=0, SCAN_BUSY=0, TBL_RD_ADDR=0; with SPRITE_SCAN_FLIPY_EN defined, entry flip=1, Y=40, LINE_Y=42 → ROW=13.
